// File: rtl/hwag_pkg.sv
// Shared definitions for the HWAG coil channel slice.
//   HWAG_ACNT_WIDTH : width of the slave angle count and of the angle registers
//   HWAG_MAX_ANGLE  : top value of the angle counter (last angle of one cycle)
//   coil_state_t    : coil channel FSM state; the encoding is visible on state_out
package hwag_pkg;

    localparam int HWAG_ACNT_WIDTH = 24;
    localparam int HWAG_MAX_ANGLE  = 3839;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SET = 2'd1,
        DWELL    = 2'd2,
        OFF_HOLD = 2'd3
    } coil_state_t;

endpackage

// File: rtl/hwag_tick_timer.sv
// Clock-tick up-counter used for the dwell and off-time limits.
//   clk, rst : system clock, asynchronous active-low reset
//   clr      : synchronous clear to 0 (wins over en)
//   en       : count one tick; the counter saturates at all-ones
//   term     : terminal value compared against the count
//   hit      : count == term, or count >= term when TERM_GE is set
module hwag_tick_timer #(
    parameter int TIME_WIDTH = 24,
    parameter bit TERM_GE    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [TIME_WIDTH-1:0] term,
    output logic                  hit
);

    logic [TIME_WIDTH-1:0] count;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + TIME_WIDTH'(1);
        end
    end

    assign hit = TERM_GE ? (count >= term) : (count == term);

endmodule

// File: rtl/hwag_coil_channel.sv
// One ignition coil channel driven by the HWAG slave angle counter.
//   clk, rst          : system clock, asynchronous active-low reset
//   hwag_start        : angle generator synchronised; 0 forces the channel idle
//   acnt, acnt_step   : running angle count and its one-clk "new value" strobe
//   set_angle_in,
//   reset_angle_in,
//   angles_wr         : dwell-start / fire angles, loaded into a pending shadow
//   max_dwell         : dwell limit in clk ticks (0 = unlimited)
//   min_off           : minimum coil-off time in clk ticks
//   flag_clr          : clears the sticky flags
//   coil_out          : registered coil drive
//   state_out         : FSM state encoding
//   angles_pending    : shadow angles waiting for the cycle wrap
//   overdwell_flag,
//   missed_set_flag,
//   wr_err_flag       : sticky event flags
module hwag_coil_channel
    import hwag_pkg::*;
#(
    parameter int ACNT_WIDTH = HWAG_ACNT_WIDTH,
    parameter int TIME_WIDTH = 24,
    parameter int MAX_ANGLE  = HWAG_MAX_ANGLE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hwag_start,
    input  logic [ACNT_WIDTH-1:0] acnt,
    input  logic                  acnt_step,
    input  logic [ACNT_WIDTH-1:0] set_angle_in,
    input  logic [ACNT_WIDTH-1:0] reset_angle_in,
    input  logic                  angles_wr,
    input  logic [TIME_WIDTH-1:0] max_dwell,
    input  logic [TIME_WIDTH-1:0] min_off,
    input  logic                  flag_clr,
    output logic                  coil_out,
    output logic [1:0]            state_out,
    output logic                  angles_pending,
    output logic                  overdwell_flag,
    output logic                  missed_set_flag,
    output logic                  wr_err_flag
);

    localparam logic [ACNT_WIDTH-1:0] MAX_A = ACNT_WIDTH'(MAX_ANGLE);

    coil_state_t           state;
    logic [ACNT_WIDTH-1:0] set_active, reset_active, set_pending, reset_pending;

    // Angle hits are equality-only and qualified by the strobe, so a dwell
    // window that spans the MAX_ANGLE -> 0 wrap needs no special handling.
    logic strobe_set, strobe_reset, cycle_wrap, transfer;
    logic wr_valid, wr_reject;
    logic dwell_hit, off_hit, forced_exit, off_done;
    logic overdwell_evt, missed_evt;

    assign strobe_set   = acnt_step && (acnt == set_active);
    assign strobe_reset = acnt_step && (acnt == reset_active);
    assign cycle_wrap   = acnt_step && (acnt == MAX_A);
    assign transfer     = cycle_wrap || (state == IDLE);

    assign wr_valid  = angles_wr && (set_angle_in <= MAX_A) && (reset_angle_in <= MAX_A);
    assign wr_reject = angles_wr && !wr_valid;

    // Dwell timer reads 0 on the first DWELL clock, so hitting max_dwell-1
    // ends the dwell exactly max_dwell ticks after coil_out rose.
    hwag_tick_timer #(.TIME_WIDTH(TIME_WIDTH), .TERM_GE(1'b0)) u_dwell_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != DWELL),
        .en   (1'b1),
        .term (max_dwell - TIME_WIDTH'(1)),
        .hit  (dwell_hit)
    );

    hwag_tick_timer #(.TIME_WIDTH(TIME_WIDTH), .TERM_GE(1'b1)) u_off_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != OFF_HOLD),
        .en   (1'b1),
        .term (min_off - TIME_WIDTH'(1)),
        .hit  (off_hit)
    );

    assign forced_exit = (max_dwell != '0) && dwell_hit;
    // min_off-1 wraps to all-ones for 0, so a zero limit is treated as one tick.
    assign off_done    = (min_off == '0) || off_hit;

    // The normal fire angle wins over the time limit in the same clock.
    assign overdwell_evt = hwag_start && (state == DWELL) && !strobe_reset && forced_exit;
    assign missed_evt    = hwag_start && (state == OFF_HOLD) && strobe_set;

    // Pending shadow and active angles. A write coinciding with a transfer
    // goes straight through to the active registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_pending    <= '0;
            reset_pending  <= '0;
            set_active     <= '0;
            reset_active   <= '0;
            angles_pending <= 1'b0;
        end else begin
            if (wr_valid) begin
                set_pending   <= set_angle_in;
                reset_pending <= reset_angle_in;
            end
            if (transfer) begin
                set_active     <= wr_valid ? set_angle_in   : set_pending;
                reset_active   <= wr_valid ? reset_angle_in : reset_pending;
                angles_pending <= 1'b0;
            end else if (wr_valid) begin
                angles_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            coil_out <= 1'b0;
        end else if (!hwag_start) begin
            state    <= IDLE;
            coil_out <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= WAIT_SET;
                WAIT_SET: begin
                    // Equal set and fire angles disable the channel.
                    if (strobe_set && (set_active != reset_active)) begin
                        state    <= DWELL;
                        coil_out <= 1'b1;
                    end
                end
                DWELL: begin
                    if (strobe_reset || forced_exit) begin
                        state    <= OFF_HOLD;
                        coil_out <= 1'b0;
                    end
                end
                OFF_HOLD: begin
                    if (off_done) state <= WAIT_SET;
                end
                default: begin
                    state    <= IDLE;
                    coil_out <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a set event in the same clock beats flag_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overdwell_flag  <= 1'b0;
            missed_set_flag <= 1'b0;
            wr_err_flag     <= 1'b0;
        end else begin
            overdwell_flag  <= overdwell_evt | (overdwell_flag  & ~flag_clr);
            missed_set_flag <= missed_evt    | (missed_set_flag & ~flag_clr);
            wr_err_flag     <= wr_reject     | (wr_err_flag     & ~flag_clr);
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_hwag_coil_channel.sv
`timescale 1ns/1ps
module tb_hwag_coil_channel;

    localparam int AW   = 24;
    localparam int TW   = 24;
    localparam int MAXA = 3839;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hwag_start = 1'b0;
    logic [AW-1:0] acnt = '0;
    logic          acnt_step = 1'b0;
    logic [AW-1:0] set_angle_in = '0;
    logic [AW-1:0] reset_angle_in = '0;
    logic          angles_wr = 1'b0;
    logic [TW-1:0] max_dwell = '0;
    logic [TW-1:0] min_off = '0;
    logic          flag_clr = 1'b0;

    logic          coil_out;
    logic [1:0]    state_out;
    logic          angles_pending;
    logic          overdwell_flag;
    logic          missed_set_flag;
    logic          wr_err_flag;

    always #5 clk = ~clk;

    hwag_coil_channel #(.ACNT_WIDTH(AW), .TIME_WIDTH(TW), .MAX_ANGLE(MAXA)) dut (
        .clk             (clk),
        .rst             (rst),
        .hwag_start      (hwag_start),
        .acnt            (acnt),
        .acnt_step       (acnt_step),
        .set_angle_in    (set_angle_in),
        .reset_angle_in  (reset_angle_in),
        .angles_wr       (angles_wr),
        .max_dwell       (max_dwell),
        .min_off         (min_off),
        .flag_clr        (flag_clr),
        .coil_out        (coil_out),
        .state_out       (state_out),
        .angles_pending  (angles_pending),
        .overdwell_flag  (overdwell_flag),
        .missed_set_flag (missed_set_flag),
        .wr_err_flag     (wr_err_flag)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode numbers follow the published state encoding,
    // time limits are measured as elapsed clock edges since a mode was entered.
    int     m_mode;
    bit     m_coil;
    int     m_set_a, m_rst_a, m_set_p, m_rst_p;
    bit     m_pend, m_ovd, m_miss, m_err;
    longint edge_n  = 0;
    longint m_enter = 0;

    task automatic model_reset();
        m_mode = 0; m_coil = 0;
        m_set_a = 0; m_rst_a = 0; m_set_p = 0; m_rst_p = 0;
        m_pend = 0; m_ovd = 0; m_miss = 0; m_err = 0;
        m_enter = edge_n;
    endtask

    task automatic model_step();
        bit     hit_set, hit_rst, xfer, wr_ok, ovd, miss, ncoil;
        int     nxt;
        longint off_need;
        edge_n++;
        if (!rst) begin
            model_reset();
            return;
        end
        hit_set = acnt_step && (int'(acnt) == m_set_a);
        hit_rst = acnt_step && (int'(acnt) == m_rst_a);
        xfer    = (acnt_step && int'(acnt) == MAXA) || (m_mode == 0);
        wr_ok   = angles_wr && (int'(set_angle_in) <= MAXA) && (int'(reset_angle_in) <= MAXA);
        off_need = (min_off == 0) ? 1 : longint'(min_off);
        ovd = 0; miss = 0; nxt = m_mode; ncoil = m_coil;
        if (!hwag_start) begin
            nxt = 0; ncoil = 0;
        end else begin
            case (m_mode)
                0: nxt = 1;
                1: if (hit_set && m_set_a != m_rst_a) begin nxt = 2; ncoil = 1; end
                2: begin
                    if (hit_rst) begin
                        nxt = 3; ncoil = 0;
                    end else if (max_dwell != 0 && (edge_n - m_enter) == longint'(max_dwell)) begin
                        nxt = 3; ncoil = 0; ovd = 1;
                    end
                end
                default: begin
                    if (hit_set) miss = 1;
                    if ((edge_n - m_enter) >= off_need) nxt = 1;
                end
            endcase
        end
        // Write first, then transfer: a coinciding write naturally wins.
        if (wr_ok) begin
            m_set_p = int'(set_angle_in);
            m_rst_p = int'(reset_angle_in);
        end
        if (xfer) begin
            m_set_a = m_set_p; m_rst_a = m_rst_p; m_pend = 0;
        end else if (wr_ok) begin
            m_pend = 1;
        end
        if (flag_clr) begin m_ovd = 0; m_miss = 0; m_err = 0; end
        if (ovd)  m_ovd  = 1;
        if (miss) m_miss = 1;
        if (angles_wr && !wr_ok) m_err = 1;
        if (nxt != m_mode) m_enter = edge_n;
        m_mode = nxt;
        m_coil = ncoil;
    endtask

    task automatic compare_all();
        check("coil_out", coil_out, m_coil);
        check("state_out", state_out, m_mode);
        check("angles_pending", angles_pending, m_pend);
        check("overdwell_flag", overdwell_flag, m_ovd);
        check("missed_set_flag", missed_set_flag, m_miss);
        check("wr_err_flag", wr_err_flag, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic strobe(input int a, input int gap);
        acnt = AW'(a);
        acnt_step = 1'b1;
        tick();
        acnt_step = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic sweep(input int from, input int to, input int gap);
        for (int a = from; a <= to; a++) strobe(a, gap);
    endtask

    task automatic write_angles(input int s, input int r);
        set_angle_in   = AW'(s);
        reset_angle_in = AW'(r);
        angles_wr = 1'b1;
        tick();
        angles_wr = 1'b0;
    endtask

    // Passing through IDLE transfers the written angles immediately.
    task automatic load_idle(input int s, input int r);
        hwag_start = 1'b0;
        tick();
        write_angles(s, r);
        hwag_start = 1'b1;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int ra;
        int n;
        model_reset();
        tick();
        tick();
        check("rst_coil", coil_out, 0);
        check("rst_state", state_out, 0);
        check("rst_pending", angles_pending, 0);
        rst = 1'b1;
        tick();

        // Basic dwell 100..200.
        write_angles(100, 200);
        hwag_start = 1'b1;
        tick();
        check("s1_wait_set", state_out, 1);
        for (int a = 0; a <= MAXA; a++) begin
            strobe(a, 1);
            if (a == 99)  check("s1_before_set", coil_out, 0);
            if (a == 100) begin check("s1_rise", coil_out, 1); check("s1_dwell", state_out, 2); end
            if (a == 200) begin check("s1_fall", coil_out, 0); check("s1_off_hold", state_out, 3); end
            if (a == 201) check("s1_back_wait", state_out, 1);
        end

        // Dwell across the cycle wrap.
        load_idle(3800, 40);
        sweep(3700, 3799, 1);
        check("s2_pre", coil_out, 0);
        strobe(3800, 1);
        check("s2_rise", coil_out, 1);
        sweep(3801, MAXA, 1);
        for (int a = 0; a <= 60; a++) begin
            strobe(a, 1);
            if (a == 0)  check("s2_through_wrap", coil_out, 1);
            if (a == 39) check("s2_before_fire", coil_out, 1);
            if (a == 40) check("s2_fire", coil_out, 0);
        end
        check("s2_no_overdwell", overdwell_flag, 0);

        // Dwell time limit.
        load_idle(100, 200);
        max_dwell = TW'(50);
        sweep(90, 99, 10);
        strobe(100, 1);
        check("s3_rise", coil_out, 1);
        n = 0;
        while (coil_out === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("s3_dwell_len", n, 50);
        check("s3_overdwell", overdwell_flag, 1);
        for (int a = 106; a <= 210; a++) begin
            strobe(a, 10);
            if (a == 200) begin check("s3_fire_ignored", coil_out, 0); check("s3_state", state_out, 1); end
        end
        max_dwell = '0;

        // Double buffering and rejected write.
        load_idle(100, 200);
        sweep(0, 99, 1);
        strobe(100, 1);
        check("s4_old_set", coil_out, 1);
        sweep(101, 300, 1);
        write_angles(500, 600);
        check("s4_pending", angles_pending, 1);
        sweep(301, 400, 1);
        write_angles(4000, 10);
        check("s4_wr_err", wr_err_flag, 1);
        check("s4_pending_kept", angles_pending, 1);
        sweep(401, MAXA - 1, 1);
        check("s4_pending_late", angles_pending, 1);
        strobe(MAXA, 1);
        check("s4_transferred", angles_pending, 0);
        for (int a = 0; a <= 700; a++) begin
            strobe(a, 1);
            if (a == 100) check("s4_old_gone", coil_out, 0);
            if (a == 500) check("s4_new_set", coil_out, 1);
            if (a == 600) check("s4_new_fire", coil_out, 0);
        end

        // Minimum off time swallowing a set.
        min_off = TW'(1000);
        load_idle(2, 3837);
        sweep(0, MAXA, 1);
        check("s5_fired", coil_out, 0);
        for (int a = 0; a <= 20; a++) begin
            strobe(a, 1);
            if (a == 2) begin
                check("s5_missed", missed_set_flag, 1);
                check("s5_coil_low", coil_out, 0);
                check("s5_off_hold", state_out, 3);
            end
        end
        sweep(21, MAXA, 1);
        sweep(0, 2, 1);
        check("s5_next_cycle", coil_out, 1);
        min_off = '0;
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check("clr_overdwell", overdwell_flag, 0);
        check("clr_missed", missed_set_flag, 0);
        check("clr_wr_err", wr_err_flag, 0);

        // hwag_start drop and asynchronous reset during DWELL.
        load_idle(100, 200);
        write_angles(4000, 1);
        sweep(95, 120, 1);
        check("s6_dwell", state_out, 2);
        hwag_start = 1'b0;
        tick();
        check("s6_drop_coil", coil_out, 0);
        check("s6_drop_state", state_out, 0);
        hwag_start = 1'b1;
        tick();
        sweep(95, 120, 1);
        check("s6_dwell_again", coil_out, 1);
        rst = 1'b0;
        #1;
        check("s6_rst_coil", coil_out, 0);
        check("s6_rst_state", state_out, 0);
        check("s6_rst_pending", angles_pending, 0);
        check("s6_rst_wr_err", wr_err_flag, 0);
        check("s6_rst_overdwell", overdwell_flag, 0);
        check("s6_rst_missed", missed_set_flag, 0);
        model_reset();
        tick();
        rst = 1'b1;
        tick();

        // Randomized traffic against the model.
        ra = 0;
        for (int seg = 0; seg < 6; seg++) begin
            max_dwell = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 80));
            min_off   = TW'($urandom_range(0, 60));
            hwag_start = 1'b1;
            for (int k = 0; k < 4000; k++) begin
                acnt_step = ($urandom_range(0, 1) == 0);
                if (acnt_step) begin
                    ra = (ra == MAXA) ? 0 : ra + 1;
                    acnt = AW'(ra);
                end
                angles_wr = ($urandom_range(0, 299) == 0);
                if (angles_wr) begin
                    case ($urandom_range(0, 9))
                        0: begin
                            set_angle_in   = AW'($urandom_range(MAXA + 1, MAXA + 500));
                            reset_angle_in = AW'($urandom_range(0, MAXA));
                        end
                        1: begin
                            set_angle_in   = AW'($urandom_range(0, MAXA));
                            reset_angle_in = set_angle_in;
                        end
                        default: begin
                            set_angle_in   = AW'($urandom_range(0, MAXA));
                            reset_angle_in = AW'($urandom_range(0, MAXA));
                        end
                    endcase
                end
                flag_clr = ($urandom_range(0, 499) == 0);
                if ($urandom_range(0, 1999) == 0) hwag_start = ~hwag_start;
                else if (!hwag_start && $urandom_range(0, 9) == 0) hwag_start = 1'b1;
                tick();
            end
        end
        acnt_step = 1'b0;
        angles_wr = 1'b0;
        flag_clr  = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hwag_coil_channel.md
Name: hwag_coil_channel

Overview:
Downstream consumer of the angle generator's slave angle counter; one instance per ignition coil pair.
- Takes the running angle count (0..3839 per cycle) and its step strobe.
- Drives the coil output between a programmable set (dwell start) angle and reset (fire) angle.
- Double-buffers the angle values so updates take effect only at the cycle wrap.
- Enforces a maximum dwell time and a minimum off time in clock ticks, independent of angle.

Parameters:
ACNT_WIDTH, 24, width of angle count and angle registers
TIME_WIDTH, 24, width of dwell/off timers and limits
MAX_ANGLE, 3839, last angle value of one cycle (angle counter top)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
hwag_start  in  1  angle generator synchronised; 0 forces the channel idle
acnt  in  ACNT_WIDTH  current angle count
acnt_step  in  1  one-clk strobe, acnt holds a new value this cycle
set_angle_in  in  ACNT_WIDTH  new dwell-start angle
reset_angle_in  in  ACNT_WIDTH  new fire angle
angles_wr  in  1  one-clk strobe, load both angles into pending shadow
max_dwell  in  TIME_WIDTH  dwell limit in clk ticks; 0 = no limit
min_off  in  TIME_WIDTH  minimum coil-off time in clk ticks
flag_clr  in  1  clears the sticky flags
coil_out  out  1  coil drive, registered
state_out  out  2  current FSM state encoding
angles_pending  out  1  pending shadow not yet transferred
overdwell_flag  out  1  sticky: dwell ended by time limit
missed_set_flag  out  1  sticky: set angle hit while in OFF_HOLD
wr_err_flag  out  1  sticky: angles_wr rejected

Behaviour:
- Reset (rst=0, async): coil_out=0; state=IDLE; active and pending angles=0; timers=0; all flags=0; angles_pending=0.
- angles_wr:
  - If set_angle_in>MAX_ANGLE or reset_angle_in>MAX_ANGLE, the write is ignored and wr_err_flag sets.
  - Otherwise pending<=inputs and angles_pending=1 on the next clk.
  - A second write before transfer overwrites pending.
- Pending-to-active transfer happens on either event; angles_pending clears the same clk.
  - acnt_step with acnt==MAX_ANGLE.
  - Any clk while state==IDLE.
  - If angles_wr coincides with a transfer, the new write wins: pending gets the new values, active gets the new values, angles_pending=0.
- States: IDLE=0, WAIT_SET=1, DWELL=2, OFF_HOLD=3.
  - Any state, hwag_start=0: next state IDLE, coil_out=0 next clk. This overrides all other transitions.
  - IDLE: go to WAIT_SET when hwag_start=1.
  - WAIT_SET: go to DWELL on acnt_step && acnt==set_active && set_active!=reset_active. coil_out=1 on the clk after the strobe (1-cycle latency). Dwell timer clears to 0. If set_active==reset_active the channel is disabled and stays in WAIT_SET.
  - DWELL: the dwell timer increments every clk and saturates at all-ones.
    - Normal exit: acnt_step && acnt==reset_active. Go to OFF_HOLD, coil_out=0 next clk.
    - Forced exit: max_dwell!=0 && timer==max_dwell-1. Go to OFF_HOLD, coil_out=0 next clk, overdwell_flag sets.
    - If both exits occur in the same clk, take the normal exit; overdwell_flag is not set.
  - OFF_HOLD: the off timer counts from 0 and exits to WAIT_SET when timer>=min_off-1; min_off=0 means exit after 1 clk. A set-angle hit while in OFF_HOLD is not executed and sets missed_set_flag.
- Angle wrap: when set_active>reset_active, dwell spans the MAX_ANGLE→0 wrap.
  - No special case is needed, because comparisons are equality-only on strobes.
  - Angles are compared against the active registers only; a transfer at MAX_ANGLE is visible from angle 0 onward.
- flag_clr clears all sticky flags. If a set event occurs in the same clk, the set wins.
- Comparisons are unsigned equality against acnt, qualified only by acnt_step. Non-strobe cycles never trigger transitions.

Decomposition:
- Shared package hwag_pkg holds:
  - ACNT width constant (24).
  - MAX_ANGLE constant (3839).
  - 2-bit state typedef with IDLE/WAIT_SET/DWELL/OFF_HOLD.
- One sub-module, hwag_tick_timer: TIME_WIDTH up-counter with synchronous clear, enable, saturation and a terminal-compare output. It is instantiated twice, for the dwell and off timers.

Test Plan:
- Reset, then hwag_start=1 with set=100, reset=200 written while in IDLE. Step acnt 0..3839. Expect coil_out rises 1 clk after the acnt=100 strobe, falls 1 clk after the acnt=200 strobe, and state sequence 1→2→3→1.
- Wrap case: set=3800, reset=40. Expect coil_out high from strobe 3800 through the wrap until strobe 40; overdwell_flag stays 0 with max_dwell=0.
- max_dwell=50, strobes 10 clk apart, set=100, reset=200. Expect coil_out falls 50 clks after rising, overdwell_flag=1, and the acnt=200 strobe has no effect.
- In mid-cycle, write set=500/reset=600 while active is 100/200. Expect angles_pending=1 until strobe acnt=3839, old angles used for the rest of this cycle, new ones the next cycle. Then write set=4000: expect wr_err_flag=1 and pending unchanged.
- min_off=1000 with set occurring 5 clks after reset. Expect the set is skipped, missed_set_flag=1, and coil_out stays 0 until the next cycle.
- Drop hwag_start during DWELL, then assert rst low mid-DWELL. Expect coil_out=0 next clk (immediately on rst), state=IDLE, and all flags and outputs at their reset values.
